// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// - ALU op encodings (3-bit, same as the single-cycle ALU)
// - FSM state encodings
// - Bit positions of the N/Z/C/V flags inside the packed flag register
// - Shift direction encoding used by alu_shift_step
package alu_pkg;

  localparam logic [2:0] OP_NOOP0 = 3'b000;
  localparam logic [2:0] OP_NOOP1 = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_ADDI  = 3'b110;
  localparam logic [2:0] OP_SUBI  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic DIR_SHL = 1'b0;
  localparam logic DIR_SHR = 1'b1;

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter, shared by SHL and SHR.
// Ports:
//   acc      in  WIDTH  value being shifted
//   s        in  SW     shift amount this cycle, 0..STEP (0 passes acc through)
//   dir      in  1      DIR_SHL / DIR_SHR (logical)
//   acc_next out WIDTH  shifted value
//   bit_out  out 1      last bit shifted out (acc[WIDTH-s] left, acc[s-1] right)
// Only the amounts 1..STEP are decoded, so the mux is STEP-wide rather than a
// full barrel shifter.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SW    = 6
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [SW-1:0]    s,
  input  logic             dir,
  output logic [WIDTH-1:0] acc_next,
  output logic             bit_out
);

  always_comb begin
    acc_next = acc;
    bit_out  = 1'b0;
    for (int k = 1; k <= STEP; k++) begin
      if (s == SW'(k)) begin
        if (dir == DIR_SHR) begin
          acc_next = acc >> k;
          bit_out  = acc[k-1];
        end else begin
          acc_next = acc << k;
          bit_out  = acc[WIDTH-k];
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle parametrised ALU with valid/ready on both sides.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake; accept = in_valid & in_ready
//   A, B, ALUop              operands and 3-bit op (B is the shift amount for shifts)
//   out_valid / out_ready    result handshake; handoff = out_valid & out_ready
//   Result                   registered result
//   flag_n/z/c/v             registered flags
//   dbg_state                current FSM state (state_t encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds its payload stable until that edge. in_ready
// does not depend on in_valid, and out_valid does not depend on out_ready.
// Non-shift ops complete at the accept edge; shifts iterate SHIFT_STEP bits per
// cycle in S_SHIFT. Accepting in S_DONE while handing off gives one op/cycle.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [1:0]       dbg_state
);

  // Counter only ever holds 1..WIDTH-1, so it is sized for WIDTH.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    STEP_V  = CW'(SHIFT_STEP);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             dir;
  logic [3:0]       flags;

  logic             accept;
  logic             is_shift;
  logic             b_zero;
  logic             b_big;
  logic             go_shift;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [CW-1:0]    s;
  logic [WIDTH-1:0] acc_shifted;
  logic             bit_out;
  logic             last_step;

  assign in_ready  = !rst && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  assign is_shift = (ALUop == OP_SHL) || (ALUop == OP_SHR);
  assign b_zero   = (B == '0);
  assign b_big    = (B >= WIDTH_V);
  assign go_shift = is_shift && !b_zero && !b_big;

  // WIDTH+1-bit sum/difference: the top bit is carry-out for add and borrow
  // (A < B unsigned) for subtract.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // Single-cycle results, including the degenerate shifts (B==0, B>=WIDTH).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL, OP_SHR: alu_res = b_zero ? A : '0;
      default:        alu_res = '0;
    endcase
  end

  assign s         = (cnt < STEP_V) ? cnt : STEP_V;
  assign last_step = (cnt == s);

  alu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (SHIFT_STEP),
    .SW    (CW)
  ) u_shift_step (
    .acc      (acc),
    .s        (s),
    .dir      (dir),
    .acc_next (acc_shifted),
    .bit_out  (bit_out)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)                           state_next = go_shift ? S_SHIFT : S_DONE;
        else if (state == S_DONE && out_ready) state_next = S_IDLE;
      end
      S_SHIFT: if (last_step) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      Result <= '0;
      flags  <= '0;
      acc    <= '0;
      cnt    <= '0;
      dir    <= DIR_SHL;
    end else begin
      state <= state_next;
      if (accept) begin
        if (go_shift) begin
          acc <= A;
          cnt <= B[CW-1:0];
          dir <= (ALUop == OP_SHR) ? DIR_SHR : DIR_SHL;
        end else begin
          Result         <= alu_res;
          flags[FLAG_N]  <= alu_res[WIDTH-1];
          flags[FLAG_Z]  <= (alu_res == '0);
          flags[FLAG_C]  <= alu_c;
          flags[FLAG_V]  <= alu_v;
        end
      end else if (state == S_SHIFT) begin
        acc           <= acc_shifted;
        cnt           <= cnt - s;
        // Carry tracks the most recent bit out; out_valid is low here, so
        // updating it mid-shift is invisible to the consumer.
        flags[FLAG_C] <= bit_out;
        if (last_step) begin
          Result        <= acc_shifted;
          flags[FLAG_N] <= acc_shifted[WIDTH-1];
          flags[FLAG_Z] <= (acc_shifted == '0);
          flags[FLAG_V] <= 1'b0;
        end
      end
    end
  end

  assign flag_n = flags[FLAG_N];
  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc: one instance with SHIFT_STEP=1 and one with
// SHIFT_STEP=4 share clock, reset and operands. All sampling and driving is
// done 1 time unit after the rising edge.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_valid4 = 1'b0;
  logic          out_ready = 1'b1, out_ready4 = 1'b1;
  logic [W-1:0]  A = '0, B = '0;
  logic [2:0]    ALUop = OP_NOOP0;

  logic          in_ready, in_ready4, out_valid, out_valid4;
  logic [W-1:0]  Result, Result4;
  logic          flag_n, flag_z, flag_c, flag_v;
  logic          flag_n4, flag_z4, flag_c4, flag_v4;
  logic [1:0]    dbg_state, dbg_state4;
  logic [3:0]    nzcv, nzcv4;

  assign nzcv  = {flag_n, flag_z, flag_c, flag_v};
  assign nzcv4 = {flag_n4, flag_z4, flag_c4, flag_v4};

  int passed = 0;
  int total  = 0;

  alu_mc #(.WIDTH(W), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .dbg_state(dbg_state)
  );

  alu_mc #(.WIDTH(W), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid4), .out_ready(out_ready4),
    .Result(Result4), .flag_n(flag_n4), .flag_z(flag_z4), .flag_c(flag_c4),
    .flag_v(flag_v4), .dbg_state(dbg_state4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present an op to instance `which` (0: step 1, 1: step 4) and return at
  // 1 time unit after the accept edge.
  task automatic send(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op);
    int n;
    A = a; B = b; ALUop = op;
    if (which == 0) in_valid = 1'b1; else in_valid4 = 1'b1;
    #1;
    n = 0;
    while (((which == 0) ? !in_ready : !in_ready4) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
  endtask

  // Count rising edges after the accept edge until out_valid is seen.
  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (!((which == 0) ? out_valid : out_valid4) && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ALUop = OP_ADD; A = 32'd1; B = 32'd1; in_valid = 1'b1; in_valid4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else passed++;
    total++; if (in_ready4 !== 1'b0) $display("FAIL rst_in_ready4: got %b expected 0", in_ready4); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (Result !== 32'h0) $display("FAIL rst_result: got %h expected 00000000", Result); else passed++;
    total++; if (nzcv !== 4'b0000) $display("FAIL rst_flags: got %b expected 0000", nzcv); else passed++;
    total++; if (dbg_state !== S_IDLE) $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_IDLE); else passed++;
    total++; if (out_valid4 !== 1'b0) $display("FAIL rst_out_valid4: got %b expected 0", out_valid4); else passed++;
    in_valid = 1'b0; in_valid4 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_arith();
    logic [W-1:0] va [8] = '{32'h7FFFFFFF, 32'd3,        32'd5,  32'hFFFFFFFF,
                             32'h10,       32'h80000000, 32'd5,  32'd100};
    logic [W-1:0] vb [8] = '{32'd1,        32'd5,        32'd5,  32'd1,
                             32'hFFFFFFF0, 32'd1,        32'd6,  32'd23};
    logic [2:0]   vo [8] = '{OP_ADD,  OP_SUB,  OP_SUB,  OP_ADD,
                             OP_ADDI, OP_SUBI, OP_NOOP1, OP_NOOP0};
    logic [W-1:0] vr [8] = '{32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h0,
                             32'h0,        32'h7FFFFFFF, 32'h0, 32'h0};
    logic [3:0]   vf [8] = '{4'b1001, 4'b1010, 4'b0100, 4'b0110,
                             4'b0110, 4'b0001, 4'b0100, 4'b0100};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, va[i], vb[i], vo[i]);
      // Registered at the accept edge: visible right after it.
      total++; if (out_valid !== 1'b1) $display("FAIL arith%0d_valid: got %b expected 1", i, out_valid); else passed++;
      total++; if (Result !== vr[i]) $display("FAIL arith%0d_result: got %h expected %h", i, Result, vr[i]); else passed++;
      total++; if (nzcv !== vf[i]) $display("FAIL arith%0d_nzcv: got %b expected %b", i, nzcv, vf[i]); else passed++;
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] va [8] = '{32'h80000001, 32'hF, 32'h1,  32'h1234,
                             32'h1,        32'h80000000, 32'hFFFFFFFF, 32'h6};
    logic [W-1:0] vb [8] = '{32'd4, 32'd3, 32'd32, 32'd0, 32'd31, 32'd31, 32'd100, 32'd2};
    logic [2:0]   vo [8] = '{OP_SHL, OP_SHR, OP_SHR, OP_SHL, OP_SHL, OP_SHR, OP_SHL, OP_SHR};
    logic [W-1:0] vr [8] = '{32'h10, 32'h1, 32'h0, 32'h1234,
                             32'h80000000, 32'h1, 32'h0, 32'h1};
    logic [3:0]   vf [8] = '{4'b0000, 4'b0010, 4'b0100, 4'b0000,
                             4'b1000, 4'b0000, 4'b0100, 4'b0010};
    int           vl [8] = '{4, 3, 0, 0, 31, 31, 0, 2};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, va[i], vb[i], vo[i]);
      if (vl[i] > 0) begin
        total++; if (in_ready !== 1'b0) $display("FAIL shl%0d_busy: in_ready got %b expected 0", i, in_ready); else passed++;
      end
      wait_valid(0, lat);
      total++; if (lat !== vl[i]) $display("FAIL shift%0d_latency: got %0d expected %0d", i, lat, vl[i]); else passed++;
      total++; if (Result !== vr[i]) $display("FAIL shift%0d_result: got %h expected %h", i, Result, vr[i]); else passed++;
      total++; if (nzcv !== vf[i]) $display("FAIL shift%0d_nzcv: got %b expected %b", i, nzcv, vf[i]); else passed++;
    end
  endtask

  task automatic test_shift_step4();
    logic [W-1:0] va [4] = '{32'h80000001, 32'hF, 32'h0F000000, 32'h100};
    logic [W-1:0] vb [4] = '{32'd4, 32'd3, 32'd6, 32'd9};
    logic [2:0]   vo [4] = '{OP_SHL, OP_SHR, OP_SHL, OP_SHR};
    logic [W-1:0] vr [4] = '{32'h10, 32'h1, 32'hC0000000, 32'h0};
    logic [3:0]   vf [4] = '{4'b0000, 4'b0010, 4'b1010, 4'b0110};
    int           vl [4] = '{1, 1, 2, 3};
    int lat;
    out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1, va[i], vb[i], vo[i]);
      wait_valid(1, lat);
      total++; if (lat !== vl[i]) $display("FAIL step4_%0d_latency: got %0d expected %0d", i, lat, vl[i]); else passed++;
      total++; if (Result4 !== vr[i]) $display("FAIL step4_%0d_result: got %h expected %h", i, Result4, vr[i]); else passed++;
      total++; if (nzcv4 !== vf[i]) $display("FAIL step4_%0d_nzcv: got %b expected %b", i, nzcv4, vf[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sa [4] = '{32'd100, 32'd105, 32'd110, 32'd115};
    logic [2:0]   so [4] = '{OP_ADD, OP_SUB, OP_ADDI, OP_SUBI};
    logic [W-1:0] sr [4] = '{32'd107, 32'd98, 32'd117, 32'd108};
    out_ready = 1'b0;
    send(0, 32'd2, 32'd2, OP_ADD);
    for (int i = 0; i < 3; i++) begin
      total++; if (Result !== 32'd4) $display("FAIL hold%0d_result: got %h expected 00000004", i, Result); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL hold%0d_valid: got %b expected 1", i, out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready: got %b expected 0", i, in_ready); else passed++;
      @(posedge clk); #1;
    end
    A = 32'd1; B = 32'd1; ALUop = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", out_valid); else passed++;
    total++; if (Result !== 32'd2) $display("FAIL b2b_result: got %h expected 00000002", Result); else passed++;
    // Streaming: one op accepted per cycle while the consumer is always ready.
    for (int i = 0; i < 4; i++) begin
      A = sa[i]; B = 32'd7; ALUop = so[i];
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL stream%0d_valid: got %b expected 1", i, out_valid); else passed++;
      total++; if (Result !== sr[i]) $display("FAIL stream%0d_result: got %0d expected %0d", i, Result, sr[i]); else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    out_ready = 1'b1;
    send(0, 32'h1, 32'd20, OP_SHL);
    repeat (4) begin @(posedge clk); #1; end
    total++; if (dbg_state !== S_SHIFT) $display("FAIL midshift_state: got %0d expected %0d", dbg_state, S_SHIFT); else passed++;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b expected 0", in_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid); else passed++;
    total++; if (Result !== 32'h0) $display("FAIL midrst_result: got %h expected 00000000", Result); else passed++;
    total++; if (nzcv !== 4'b0000) $display("FAIL midrst_flags: got %b expected 0000", nzcv); else passed++;
    total++; if (dbg_state !== S_IDLE) $display("FAIL midrst_state: got %0d expected %0d", dbg_state, S_IDLE); else passed++;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_stale_pulse: out_valid seen %0d cycles, expected 0", seen); else passed++;
    send(0, 32'd1, 32'd1, OP_ADD);
    total++; if (out_valid !== 1'b1) $display("FAIL after_rst_valid: got %b expected 1", out_valid); else passed++;
    total++; if (Result !== 32'd2) $display("FAIL after_rst_result: got %h expected 00000002", Result); else passed++;
    total++; if (nzcv !== 4'b0000) $display("FAIL after_rst_nzcv: got %b expected 0000", nzcv); else passed++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_shift_step4();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
